// File: rtl/muldiv_unit_if.sv
// Request/response bundle for the RV32M multiply/divide unit.
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [2:0]      funct3;
  logic            kill;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  // Pipeline side: issues requests and consumes results
  modport master (
    output in_valid, op1, op2, funct3, kill, out_ready,
    input  in_ready, out_valid, result, busy
  );

  // Unit side
  modport slave (
    input  in_valid, op1, op2, funct3, kill, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Shift-add multiply and restoring divide
// share one double-width accumulator; UNROLL bits are retired per CALC cycle.
module muldiv_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);
  localparam int unsigned Iter = XLEN / UNROLL;
  localparam int unsigned CntW = $clog2(Iter + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                sign1_q, sign1_d;
  logic                sign2_q, sign2_d;
  logic [XLEN-1:0]     mcand_q, mcand_d;   // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   acc_q, acc_d;       // mul: {hi, lo} product; div: {rem, dividend/quo}
  logic [XLEN-1:0]     result_q, result_d;

  logic                accept;
  logic                is_div_in;
  logic                op1_signed, op2_signed;
  logic                neg1, neg2;
  logic                div_zero, div_ovf;
  logic [XLEN-1:0]     op1_mag, op2_mag;
  logic [XLEN-1:0]     min_val;

  assign min_val    = {1'b1, {(XLEN-1){1'b0}}};
  assign accept     = bus.in_valid & (state_q == StIdle) & ~bus.kill;
  assign is_div_in  = bus.funct3[2];
  assign op1_signed = is_div_in ? ~bus.funct3[0]
                                : ((bus.funct3[1:0] == 2'b01) || (bus.funct3[1:0] == 2'b10));
  assign op2_signed = is_div_in ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01);
  assign neg1       = op1_signed & bus.op1[XLEN-1];
  assign neg2       = op2_signed & bus.op2[XLEN-1];
  assign op1_mag    = neg1 ? (~bus.op1 + 1'b1) : bus.op1;
  assign op2_mag    = neg2 ? (~bus.op2 + 1'b1) : bus.op2;
  assign div_zero   = is_div_in & (bus.op2 == '0);
  assign div_ovf    = is_div_in & ~bus.funct3[0] & (bus.op1 == min_val) & (&bus.op2);

  logic [2*XLEN-1:0]   step_acc;
  logic [XLEN:0]       step_sum;

  // UNROLL iterations of shift-add or restoring shift-subtract per cycle
  always_comb begin
    step_acc = acc_q;
    step_sum = '0;
    for (int i = 0; i < int'(UNROLL); i++) begin
      if (funct3_q[2]) begin
        step_sum = {step_acc[2*XLEN-1:XLEN], step_acc[XLEN-1]};
        if (step_sum >= {1'b0, mcand_q}) begin
          step_sum = step_sum - {1'b0, mcand_q};
          step_acc = {step_sum[XLEN-1:0], step_acc[XLEN-2:0], 1'b1};
        end else begin
          step_acc = {step_sum[XLEN-1:0], step_acc[XLEN-2:0], 1'b0};
        end
      end else begin
        step_sum = {1'b0, step_acc[2*XLEN-1:XLEN]} +
                   (step_acc[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
        step_acc = {step_sum, step_acc[XLEN-1:1]};
      end
    end
  end

  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix, fix_val;

  // Sign correction and result selection for the FIX cycle
  always_comb begin
    prod_fix = (sign1_q ^ sign2_q) ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = (sign1_q ^ sign2_q) ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_fix  = sign1_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    case (funct3_q)
      3'b000:                 fix_val = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_val = quo_fix;
      default:                fix_val = rem_fix;
    endcase
  end

  // Next-state and datapath load control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          funct3_d = bus.funct3;
          sign1_d  = neg1;
          sign2_d  = neg2;
          mcand_d  = op2_mag;
          acc_d    = {{XLEN{1'b0}}, op1_mag};
          cnt_d    = CntW'(Iter);
          if (div_zero) begin
            result_d = bus.funct3[1] ? bus.op1 : {XLEN{1'b1}};
            state_d  = StDone;
          end else if (div_ovf) begin
            result_d = bus.funct3[1] ? {XLEN{1'b0}} : min_val;
            state_d  = StDone;
          end else begin
            state_d  = StCalc;
          end
        end
      end
      StCalc: begin
        acc_d = step_acc;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) state_d = StFix;
      end
      StFix: begin
        result_d = fix_val;
        state_d  = StDone;
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Flush wins over everything; a killed FIX must not overwrite result
    if (bus.kill && (state_q != StIdle)) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      funct3_q <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench: one UNROLL=1 unit and one UNROLL=4 unit driven in lockstep.
module tb_muldiv_unit;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  muldiv_unit_if #(.XLEN(32)) ifc ();
  muldiv_unit_if #(.XLEN(32)) ifc4 ();

  muldiv_unit #(.XLEN(32), .UNROLL(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  muldiv_unit #(.XLEN(32), .UNROLL(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (ifc4)
  );

  assign ifc4.in_valid  = ifc.in_valid;
  assign ifc4.op1       = ifc.op1;
  assign ifc4.op2       = ifc.op2;
  assign ifc4.funct3    = ifc.funct3;
  assign ifc4.kill      = ifc.kill;
  assign ifc4.out_ready = ifc.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // Issue one op to both units; latency is counted in edges after the accept edge,
  // so special cases (finished on the accept edge itself) report 0.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int lat1, input int lat4);
    int          n;
    int          got1;
    int          got4;
    logic [31:0] r1;
    logic [31:0] r4;
    got1 = -1;
    got4 = -1;
    r1   = 'x;
    r4   = 'x;
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.op1      = a;
    ifc.op2      = b;
    ifc.funct3   = f;
    @(posedge clk);
    #1;
    // Operands after the accept edge must be ignored
    ifc.in_valid = 1'b0;
    ifc.op1      = 32'hDEADBEEF;
    ifc.op2      = 32'h0;
    ifc.funct3   = ~f;
    n = 0;
    while (((got1 < 0) || (got4 < 0)) && (n < 100)) begin
      @(negedge clk);
      if (ifc.out_valid && (got1 < 0)) begin
        got1 = n;
        r1   = ifc.result;
      end
      if (ifc4.out_valid && (got4 < 0)) begin
        got4 = n;
        r4   = ifc4.result;
      end
      if ((got1 < 0) || (got4 < 0)) begin
        @(posedge clk);
        n++;
      end
    end
    check_eq({tag, " res u1"}, r1, exp);
    check_eq({tag, " res u4"}, r4, exp);
    check_eq({tag, " lat u1"}, got1, lat1);
    check_eq({tag, " lat u4"}, got4, lat4);
  endtask

  initial begin
    int          n;
    logic        seen;
    rst           = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.op1       = '0;
    ifc.op2       = '0;
    ifc.funct3    = '0;
    ifc.kill      = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst out_valid", ifc.out_valid, 0);
    check_eq("rst in_ready", ifc.in_ready, 1);
    check_eq("rst busy", ifc.busy, 0);
    check_eq("rst result", ifc.result, 0);
    check_eq("rst u4 out_valid", ifc4.out_valid, 0);
    rst = 1'b0;

    run_op("mul 7*-3",       3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 9);
    run_op("mul -1*-1",      3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33, 9);
    run_op("mulh min*min",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 9);
    run_op("mulh -1*-1",     3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, 9);
    run_op("mulhu max*max",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 9);
    run_op("mulhu min*4",    3'b011, 32'h80000000, 32'd4,        32'h00000002, 33, 9);
    run_op("mulhsu -1*2",    3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, 9);
    run_op("div 5/0",        3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 0, 0);
    run_op("rem 5/0",        3'b110, 32'd5,        32'd0,        32'd5,        0, 0);
    run_op("divu 5/0",       3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 0, 0);
    run_op("remu 9/0",       3'b111, 32'd9,        32'd0,        32'd9,        0, 0);
    run_op("div ovf",        3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0);
    run_op("rem ovf",        3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0, 0);
    run_op("div -7/2",       3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 9);
    run_op("rem -7/2",       3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 9);
    run_op("div 7/-2",       3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, 9);
    run_op("rem 7/-2",       3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 33, 9);
    run_op("divu 100/7",     3'b101, 32'd100,      32'd7,        32'd14,       33, 9);
    run_op("remu 100/7",     3'b111, 32'd100,      32'd7,        32'd2,        33, 9);
    run_op("div min/1",      3'b100, 32'h80000000, 32'd1,        32'h80000000, 33, 9);
    run_op("divu min/max",   3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33, 9);
    run_op("remu min/max",   3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 9);
    run_op("divu max/1",     3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33, 9);

    // Backpressure: result held in DONE while out_ready is low
    @(negedge clk);
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.op1       = 32'd3;
    ifc.op2       = 32'd5;
    ifc.funct3    = 3'b000;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    n = 0;
    while (!ifc.out_valid && (n < 60)) begin
      @(negedge clk);
      n++;
    end
    check_eq("bp reached done", ifc.out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp result", ifc.result, 32'd15);
      check_eq("bp in_ready", ifc.in_ready, 0);
      check_eq("bp out_valid", ifc.out_valid, 1);
    end
    check_eq("bp u4 result", ifc4.result, 32'd15);
    check_eq("bp u4 out_valid", ifc4.out_valid, 1);
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("bp release out_valid", ifc.out_valid, 0);
    check_eq("bp release in_ready", ifc.in_ready, 1);
    check_eq("bp release u4 in_ready", ifc4.in_ready, 1);

    // Kill in the 5th CALC cycle
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.op1      = 32'd100;
    ifc.op2      = 32'd7;
    ifc.funct3   = 3'b101;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("kill pre busy", ifc.busy, 1);
    ifc.kill = 1'b1;
    @(posedge clk);
    #1;
    check_eq("kill in_ready", ifc.in_ready, 1);
    check_eq("kill out_valid", ifc.out_valid, 0);
    check_eq("kill u4 in_ready", ifc4.in_ready, 1);
    @(negedge clk);
    ifc.kill = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifc.out_valid || ifc4.out_valid) seen = 1'b1;
    end
    check_eq("kill no out_valid", seen, 0);
    check_eq("kill result kept", ifc.result, 32'd15);

    // Kill in IDLE blocks accept
    @(negedge clk);
    ifc.kill     = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.funct3   = 3'b100;
    ifc.op2      = 32'd0;
    @(posedge clk);
    #1;
    check_eq("idle kill busy", ifc.busy, 0);
    check_eq("idle kill out_valid", ifc.out_valid, 0);
    @(negedge clk);
    ifc.kill     = 1'b0;
    ifc.in_valid = 1'b0;

    // Asynchronous reset mid-CALC
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.op1      = 32'd6;
    ifc.op2      = 32'd7;
    ifc.funct3   = 3'b000;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst out_valid", ifc.out_valid, 0);
    check_eq("arst in_ready", ifc.in_ready, 1);
    check_eq("arst result", ifc.result, 0);
    check_eq("arst u4 in_ready", ifc4.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    run_op("mul after rst", 3'b000, 32'd6, 32'd7, 32'd42, 33, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
